cnt_seq_ctrl: RTL and testbench

Command-driven sequencer for the cut-line up/down counter datapath (step 1 below CUTLINE, step AB at or above it).
- Accepts one command at a time over a valid/ready handshake.
- Drives the counter's en/up inputs for a programmed number of cycles, or until the counter output reaches a target value.
- Reports completion, timeout and enabled-cycle count.
- Sits between the system/test sequencer and the counter top, replacing hand-driven en/up.

---
 rtl/cnt_seq_ctrl.sv | 102 ++++++++++
 tb/tb_cnt_seq_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cnt_seq_ctrl.sv
// Command sequencer for the cut-line up/down counter: runs the counter for a
// fixed number of enabled cycles, or until its output reaches a target value.
module cnt_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_up,
  input  logic             cmd_mode,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [WIDTH-1:0] cmd_target,
  input  logic             abort,
  input  logic [WIDTH-1:0] dout,
  output logic             ctr_en,
  output logic             ctr_up,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [LEN_W-1:0] steps
);

  typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

  state_t           state, next_state;
  logic             mode_q;
  logic [LEN_W-1:0] len_q;
  logic [WIDTH-1:0] target_q;
  logic             hit;
  logic             more;
  logic             finish;

  assign hit  = mode_q && (dout == target_q);
  assign more = steps < len_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    ctr_en     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        if (cmd_valid) next_state = SETUP;
      end
      SETUP: next_state = RUN;
      RUN: begin
        // Enable drops in the very cycle the target appears: no overshoot.
        ctr_en = more && !abort && !hit;
        finish = abort || hit || !more;
        if (finish) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Direction is loaded at acceptance so it is already stable throughout
  // SETUP, one full cycle ahead of the first enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= 1'b0;
      len_q    <= '0;
      target_q <= '0;
      ctr_up   <= 1'b1;
      timeout  <= 1'b0;
      steps    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            ctr_up   <= cmd_up;
            mode_q   <= cmd_mode;
            len_q    <= cmd_len;
            target_q <= cmd_target;
            steps    <= '0;
            timeout  <= 1'b0;
          end
        end
        RUN: begin
          if (ctr_en) steps <= steps + 1'b1;
          if (finish) timeout <= abort ? 1'b1 : (hit ? 1'b0 : mode_q);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Bench for cnt_seq_ctrl: drives a behavioural cut-line counter from the
// sequencer outputs and checks table, random and hand-built command runs.
module tb_cnt_seq_ctrl;
  localparam int WIDTH   = 16;
  localparam int LEN_W   = 17;
  localparam int CUTLINE = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready, cmd_up, cmd_mode, abort;
  logic [LEN_W-1:0] cmd_len;
  logic [WIDTH-1:0] cmd_target;
  logic [WIDTH-1:0] cnt;
  logic             ctr_en, ctr_up, busy, done, timeout;
  logic [LEN_W-1:0] steps;

  logic             presetReq = 1'b1;
  logic [WIDTH-1:0] presetVal = '0;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int up; int mode; int len; int target; int start; int abortAfter;
    int expSteps; int expTo; int expDout;
  } vec_t;

  vec_t tbl[10];

  cnt_seq_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_up(cmd_up), .cmd_mode(cmd_mode), .cmd_len(cmd_len), .cmd_target(cmd_target),
    .abort(abort), .dout(cnt),
    .ctr_en(ctr_en), .ctr_up(ctr_up), .busy(busy), .done(done),
    .timeout(timeout), .steps(steps)
  );

  always #5 clk = ~clk;

  // One counter step: unit below the cut line, double at or above it.
  function automatic int stepVal(input int v, input int up);
    int d;
    d = (v >= CUTLINE) ? 2 : 1;
    return up != 0 ? ((v + d) & 16'hFFFF) : ((v - d) & 16'hFFFF);
  endfunction

  always @(posedge clk) begin
    if (presetReq)   cnt <= presetVal;
    else if (ctr_en) cnt <= WIDTH'(stepVal(int'(cnt), int'(ctr_up)));
  end

  // Reference: walk the command rules one enabled cycle at a time.
  function automatic void refRun(input int up, input int mode, input int len,
                                 input int target, input int start, input int abortAfter,
                                 output int s, output int to, output int v);
    s = 0; v = start; to = 0;
    forever begin
      if (abortAfter >= 0 && s == abortAfter) begin to = 1; break; end
      if (mode != 0 && v == target)             begin to = 0; break; end
      if (s == len)                             begin to = mode; break; end
      v = stepVal(v, up);
      s++;
    end
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic presetCnt(input int v);
    @(negedge clk);
    presetReq = 1'b1;
    presetVal = WIDTH'(v);
    @(posedge clk); #1;
    presetReq = 1'b0;
  endtask

  task automatic applyStimulus(input string tag, input int up, input int mode, input int len,
                               input int target, input int abortAfter, input bit hold,
                               input int expSteps, input int expTo, input int expDout);
    int w, n, cyc, upViol, rdyViol, gotDone;
    logic prevUp;
    w = 0; n = 0; cyc = 0; upViol = 0; rdyViol = 0; gotDone = 0;
    @(negedge clk);
    while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
    cmd_up     = 1'(up);
    cmd_mode   = 1'(mode);
    cmd_len    = LEN_W'(len);
    cmd_target = WIDTH'(target);
    cmd_valid  = 1'b1;
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
    prevUp = 1'(up);
    for (int k = 0; k < len + 20; k++) begin
      abort = (abortAfter >= 0 && n >= abortAfter);
      @(negedge clk);
      cyc++;
      if (busy && cmd_ready) rdyViol++;
      if (cmd_valid && cmd_ready) rdyViol++;
      if (cyc == 1 && (ctr_en || ctr_up != 1'(up))) upViol++;
      if (ctr_en) begin
        if (ctr_up != 1'(up) || ctr_up != prevUp) upViol++;
        n++;
      end
      prevUp = ctr_up;
      if (done) begin gotDone = 1; break; end
      @(posedge clk); #1;
    end
    abort = 1'b0;
    checkOutput({tag, " done_seen"}, gotDone, 1);
    checkOutput({tag, " steps"}, int'(steps), expSteps);
    checkOutput({tag, " timeout"}, int'(timeout), expTo);
    checkOutput({tag, " dout"}, int'(cnt), expDout);
    checkOutput({tag, " enables"}, n, expSteps);
    checkOutput({tag, " latency"}, cyc, expSteps + 3);
    checkOutput({tag, " dir_stable"}, upViol, 0);
    checkOutput({tag, " no_accept_busy"}, rdyViol, 0);
  endtask

  initial begin
    int s, to, v, up, mode, len, target, start, ab, n, c;
    rst = 1'b1; cmd_valid = 1'b0; cmd_up = 1'b0; cmd_mode = 1'b0;
    cmd_len = '0; cmd_target = '0; abort = 1'b0;

    tbl[0] = '{1, 0, 200,    0,   0, -1, 200, 0, 385};
    tbl[1] = '{0, 0, 100,    0, 385, -1, 100, 0, 185};
    tbl[2] = '{1, 1, 1000,  31,   0, -1,  23, 0,  31};
    tbl[3] = '{1, 1, 100,   32,   0, -1, 100, 1, 185};
    tbl[4] = '{1, 0, 50,     0,   0,  9,   9, 1,   9};
    tbl[5] = '{1, 0, 0,      0,   7, -1,   0, 0,   7};
    tbl[6] = '{1, 1, 0,      7,   7, -1,   0, 0,   7};
    tbl[7] = '{1, 1, 0,      8,   7, -1,   0, 1,   7};
    tbl[8] = '{0, 1, 50,     0,  20, -1,  17, 0,   0};
    tbl[9] = '{0, 0, 3,      0,   1, -1,   3, 0, 65533};

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst ctr_en", int'(ctr_en), 0);
    checkOutput("rst ctr_up", int'(ctr_up), 1);
    checkOutput("rst busy", int'(busy), 0);
    checkOutput("rst done", int'(done), 0);
    checkOutput("rst timeout", int'(timeout), 0);
    checkOutput("rst steps", int'(steps), 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle cmd_ready", int'(cmd_ready), 1);
    presetReq = 1'b0;

    for (int i = 0; i < 10; i++) begin
      presetCnt(tbl[i].start);
      applyStimulus($sformatf("tbl%0d", i), tbl[i].up, tbl[i].mode, tbl[i].len,
                    tbl[i].target, tbl[i].abortAfter, 1'b0,
                    tbl[i].expSteps, tbl[i].expTo, tbl[i].expDout);
    end

    // Abort on the 10th enable with cmd_valid held throughout the command.
    presetCnt(0);
    applyStimulus("hold", 1, 0, 50, 0, 9, 1'b1, 9, 1, 9);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("reaccept cmd_ready", int'(cmd_ready), 1);
    cmd_len = '0; cmd_mode = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checkOutput("reaccept busy", int'(busy), 1);
    c = 0;
    do begin @(negedge clk); c++; end while (!done && c < 6);
    checkOutput("len0 done_latency", c, 3);

    // Reset in the middle of a down run.
    presetCnt(100);
    @(negedge clk);
    cmd_up = 1'b0; cmd_mode = 1'b0; cmd_len = LEN_W'(50); cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ctr_en) n++;
      if (n == 5) break;
    end
    checkOutput("midrun enables", n, 5);
    rst = 1'b1;
    #1;
    checkOutput("midrun rst ctr_en", int'(ctr_en), 0);
    checkOutput("midrun rst busy", int'(busy), 0);
    checkOutput("midrun rst ctr_up", int'(ctr_up), 1);
    checkOutput("midrun rst steps", int'(steps), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    presetCnt(0);
    applyStimulus("recover", 1, 0, 4, 0, -1, 1'b0, 4, 0, 4);

    for (int i = 0; i < 25; i++) begin
      up     = int'($urandom_range(0, 1));
      mode   = int'($urandom_range(0, 1));
      len    = int'($urandom_range(0, 40));
      start  = int'($urandom_range(0, 60));
      target = int'($urandom_range(0, 100));
      ab     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
      refRun(up, mode, len, target, start, ab, s, to, v);
      presetCnt(start);
      applyStimulus($sformatf("rnd%0d", i), up, mode, len, target, ab, 1'b0, s, to, v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
